// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory-port arbiter slice.
//   - WORD_LEN       : data/address width of the unified memory port.
//   - MAX_DATA_BURST : default number of consecutive data grants allowed
//                      while a fetch is waiting (starvation guard only).
//   - arb_state_t    : arbiter sequencer states.
package mem_arb_pkg;

  localparam int WORD_LEN       = 32;
  localparam int MAX_DATA_BURST = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// mem_arb_starve_cnt
//   Fetch starvation guard. Counts data grants issued while the IF stage is
//   waiting; once the count reaches MAX_DATA_BURST the arbiter lets the
//   fetch go ahead of data. Any fetch grant clears the count.
//   Only instantiated when ARB_STARVE_GUARD_EN is defined.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   data_grant   : IDLE is granting a data access this cycle
//   fetch_grant  : IDLE is granting a fetch this cycle
//   if_req       : IF stage request is pending
//   burst_hit    : count has reached MAX_DATA_BURST
module mem_arb_starve_cnt #(
  parameter int MAX_DATA_BURST = mem_arb_pkg::MAX_DATA_BURST
) (
  input  logic clk,
  input  logic rst,
  input  logic data_grant,
  input  logic fetch_grant,
  input  logic if_req,
  output logic burst_hit
);

  localparam int                CNT_W   = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_DATA_BURST);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (fetch_grant) begin
      cnt_reg <= '0;
    end else if (data_grant && if_req && (cnt_reg != CNT_MAX)) begin
      // Saturate: a flushed fetch can keep data winning past the limit.
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign burst_hit = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates one external memory port between instruction fetch (IF) and
//   load/store (MEM). Data normally has priority. The granted access is held
//   on ext_req until ext_ready, then the read data is registered and a
//   one-cycle done pulse is returned in the RESP state. Freeze outputs hold
//   the pipeline while an access is outstanding and drop in RESP so the
//   pipeline advances exactly once per access.
//   Optional macro ARB_STARVE_GUARD_EN: after MAX_DATA_BURST data grants
//   with a fetch waiting, the fetch is granted ahead of data.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   if_req, if_addr, if_flush        : fetch request, PC, branch flush
//   if_rdata, if_done                : fetched instruction, completion pulse
//   mem_r_en, mem_w_en               : load / store request
//   mem_addr, mem_wdata              : data address, store data
//   mem_rdata, mem_done              : load data, completion pulse
//   freeze_IF, freeze_all            : pipeline hold controls
//   ext_req, ext_we, ext_addr,
//   ext_wdata                        : registered memory request
//   ext_rdata, ext_ready             : memory response
module mem_port_arbiter #(
  parameter int WORD_LEN = mem_arb_pkg::WORD_LEN
`ifdef ARB_STARVE_GUARD_EN
  , parameter int MAX_DATA_BURST = mem_arb_pkg::MAX_DATA_BURST
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [WORD_LEN-1:0] if_addr,
  input  logic                if_flush,
  output logic [WORD_LEN-1:0] if_rdata,
  output logic                if_done,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  input  logic [WORD_LEN-1:0] mem_addr,
  input  logic [WORD_LEN-1:0] mem_wdata,
  output logic [WORD_LEN-1:0] mem_rdata,
  output logic                mem_done,
  output logic                freeze_IF,
  output logic                freeze_all,
  output logic                ext_req,
  output logic                ext_we,
  output logic [WORD_LEN-1:0] ext_addr,
  output logic [WORD_LEN-1:0] ext_wdata,
  input  logic [WORD_LEN-1:0] ext_rdata,
  input  logic                ext_ready
);

  import mem_arb_pkg::*;

  arb_state_t state_reg;
  arb_state_t state_next;

  logic resp_is_data_reg;
  logic flush_seen_reg;
  logic if_done_reg;

  logic data_req;
  logic grant_data;
  logic grant_fetch;
  logic fetch_first;
  logic access_ack;

  assign data_req   = mem_r_en | mem_w_en;
  // ext_ready only counts while an access is actually on the port.
  assign access_ack = ((state_reg == FETCH) || (state_reg == DATA)) && ext_ready;

`ifdef ARB_STARVE_GUARD_EN
  logic burst_hit;

  mem_arb_starve_cnt #(
    .MAX_DATA_BURST (MAX_DATA_BURST)
  ) u_starve_cnt (
    .clk         (clk),
    .rst         (rst),
    .data_grant  (grant_data),
    .fetch_grant (grant_fetch),
    .if_req      (if_req),
    .burst_hit   (burst_hit)
  );

  // burst_hit is registered, so this does not loop back through the grants.
  assign fetch_first = burst_hit && if_req && !if_flush;
`else
  assign fetch_first = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and grant decode.
  always_comb begin
    state_next  = state_reg;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fetch_first) begin
          grant_fetch = 1'b1;
          state_next  = FETCH;
        end else if (data_req) begin
          grant_data = 1'b1;
          state_next = DATA;
        end else if (if_req && !if_flush) begin
          grant_fetch = 1'b1;
          state_next  = FETCH;
        end
      end
      FETCH, DATA: begin
        if (ext_ready) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered request, response data and done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_req          <= 1'b0;
      ext_we           <= 1'b0;
      ext_addr         <= '0;
      ext_wdata        <= '0;
      if_rdata         <= '0;
      mem_rdata        <= '0;
      mem_done         <= 1'b0;
      if_done_reg      <= 1'b0;
      resp_is_data_reg <= 1'b0;
      flush_seen_reg   <= 1'b0;
    end else begin
      mem_done    <= 1'b0;
      if_done_reg <= 1'b0;

      if (grant_data) begin
        ext_req          <= 1'b1;
        ext_we           <= mem_w_en;
        ext_addr         <= mem_addr;
        ext_wdata        <= mem_wdata;
        resp_is_data_reg <= 1'b1;
      end else if (grant_fetch) begin
        ext_req          <= 1'b1;
        ext_we           <= 1'b0;
        ext_addr         <= if_addr;
        resp_is_data_reg <= 1'b0;
        flush_seen_reg   <= 1'b0;
      end

      // A flush cannot cancel the memory access; it only kills the done pulse.
      if ((state_reg == FETCH) && if_flush) begin
        flush_seen_reg <= 1'b1;
      end

      if (access_ack) begin
        ext_req <= 1'b0;
        if (resp_is_data_reg) begin
          if (!ext_we) begin
            mem_rdata <= ext_rdata;
          end
          mem_done <= 1'b1;
        end else begin
          if_rdata    <= ext_rdata;
          if_done_reg <= !(flush_seen_reg || if_flush);
        end
      end
    end
  end

  // Combinational outputs: freezes, and the fetch done pulse which must also
  // be suppressed by a flush arriving during the RESP cycle itself.
  always_comb begin
    freeze_all = data_req && !((state_reg == RESP) && resp_is_data_reg);
    freeze_IF  = freeze_all || (if_req && !((state_reg == RESP) && !resp_is_data_reg));
    if_done    = if_done_reg && !if_flush;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [W-1:0]  if_addr;
  logic          if_flush;
  logic [W-1:0]  if_rdata;
  logic          if_done;
  logic          mem_r_en;
  logic          mem_w_en;
  logic [W-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          mem_done;
  logic          freeze_IF;
  logic          freeze_all;
  logic          ext_req;
  logic          ext_we;
  logic [W-1:0]  ext_addr;
  logic [W-1:0]  ext_wdata;
  logic [W-1:0]  ext_rdata;
  logic          ext_ready;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_rdata   (if_rdata),
    .if_done    (if_done),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done),
    .freeze_IF  (freeze_IF),
    .freeze_all (freeze_all),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_rdata  (ext_rdata),
    .ext_ready  (ext_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         is_data;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endfunction

  function automatic void push(logic is_data, logic [W-1:0] data);
    exp_t e;
    e.is_data = is_data;
    e.data    = data;
    exp_q.push_back(e);
  endfunction

  // Memory model: read data is the address with a fixed pattern in the top
  // half; ready rises after wait_states request cycles.
  int wait_states = 0;
  int req_cyc     = 0;
  assign ext_rdata = ext_addr ^ 32'hA5A5_0000;

  initial begin
    ext_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ext_req) begin
        ext_ready = (req_cyc == wait_states);
        req_cyc++;
      end else begin
        ext_ready = 1'b0;
        req_cyc   = 0;
      end
    end
  end

  // Monitor: every done pulse pops one expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_done && mem_done) begin
        total++;
        bad++;
        $display("FAIL both_done: got if_done=1 mem_done=1 want one at a time");
      end else if (if_done || mem_done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got if_done=%0b mem_done=%0b want none", if_done, mem_done);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", {31'd0, mem_done}, {31'd0, e.is_data});
          if (e.is_data)
            check("mem_rdata", mem_rdata, e.data);
          else
            check("if_rdata", if_rdata, e.data);
          $display("txn %s data=%h @%0t", mem_done ? "data " : "fetch", mem_done ? mem_rdata : if_rdata, $time);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #3;
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    if_flush  = 1'b0;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #4;
    check("rst_ext_req",   {31'd0, ext_req},  0);
    check("rst_ext_we",    {31'd0, ext_we},   0);
    check("rst_ext_addr",  ext_addr,  0);
    check("rst_ext_wdata", ext_wdata, 0);
    check("rst_if_rdata",  if_rdata,  0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_dones",     {30'd0, if_done, mem_done}, 0);
    next_cycle();
    rst = 1'b0;

    // Lone fetch, zero wait states
    next_cycle();
    wait_states = 0;
    if_req  = 1'b1;
    if_addr = 32'h10;
    push(1'b0, 32'hA5A5_0010);
    #1;
    check("f_c0_freeze_IF", {31'd0, freeze_IF}, 1);
    check("f_c0_ext_req",   {31'd0, ext_req},   0);
    next_cycle(); #1;
    check("f_c1_ext_req",   {31'd0, ext_req},   1);
    check("f_c1_ext_addr",  ext_addr, 32'h10);
    check("f_c1_freeze_IF", {31'd0, freeze_IF}, 1);
    next_cycle(); #1;
    check("f_c2_if_done",   {31'd0, if_done},   1);
    check("f_c2_freeze_IF", {31'd0, freeze_IF}, 0);
    next_cycle();
    if_req = 1'b0;
    #1;
    check("f_c3_ext_req",   {31'd0, ext_req},   0);

    // Load with 3 wait states; address change mid-access must not leak
    next_cycle();
    wait_states = 3;
    mem_r_en = 1'b1;
    mem_addr = 32'h200;
    push(1'b1, 32'hA5A5_0200);
    #1;
    check("ld_c0_freeze_all", {31'd0, freeze_all}, 1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 1) mem_addr = 32'h999;
      #1;
      check("ld_ext_req",    {31'd0, ext_req},    1);
      check("ld_ext_addr",   ext_addr, 32'h200);
      check("ld_freeze_all", {31'd0, freeze_all}, 1);
    end
    next_cycle(); #1;
    check("ld_resp_mem_done",   {31'd0, mem_done},   1);
    check("ld_resp_ext_req",    {31'd0, ext_req},    0);
    check("ld_resp_freeze_all", {31'd0, freeze_all}, 0);
    next_cycle();
    mem_r_en = 1'b0;
    mem_addr = '0;

    // Simultaneous store and fetch: store first, rdata left unchanged
    next_cycle();
    wait_states = 0;
    if_req    = 1'b1;
    if_addr   = 32'h40;
    mem_w_en  = 1'b1;
    mem_addr  = 32'h300;
    mem_wdata = 32'hDEAD_BEEF;
    push(1'b1, 32'hA5A5_0200);
    push(1'b0, 32'hA5A5_0040);
    #1;
    check("sim_c0_freeze_all", {31'd0, freeze_all}, 1);
    next_cycle(); #1;
    check("sim_c1_ext_req",   {31'd0, ext_req}, 1);
    check("sim_c1_ext_we",    {31'd0, ext_we},  1);
    check("sim_c1_ext_addr",  ext_addr,  32'h300);
    check("sim_c1_ext_wdata", ext_wdata, 32'hDEAD_BEEF);
    next_cycle(); #1;
    check("sim_c2_mem_done",   {31'd0, mem_done},   1);
    check("sim_c2_freeze_all", {31'd0, freeze_all}, 0);
    check("sim_c2_freeze_IF",  {31'd0, freeze_IF},  1);
    next_cycle();
    mem_w_en = 1'b0;
    #1;
    check("sim_c3_ext_req", {31'd0, ext_req}, 0);
    next_cycle(); #1;
    check("sim_c4_ext_req",  {31'd0, ext_req}, 1);
    check("sim_c4_ext_we",   {31'd0, ext_we},  0);
    check("sim_c4_ext_addr", ext_addr, 32'h40);
    next_cycle(); #1;
    check("sim_c5_if_done",   {31'd0, if_done},   1);
    check("sim_c5_freeze_IF", {31'd0, freeze_IF}, 0);
    next_cycle();
    if_req = 1'b0;

    // Flush during a fetch with 2 wait states
    next_cycle();
    wait_states = 2;
    if_req  = 1'b1;
    if_addr = 32'h80;
    next_cycle();
    if_flush = 1'b1;
    if_req   = 1'b0;
    #1;
    check("fl_c1_ext_req", {31'd0, ext_req}, 1);
    next_cycle();
    if_flush = 1'b0;
    next_cycle(); #1;
    check("fl_c3_ext_req", {31'd0, ext_req}, 1);
    next_cycle(); #1;
    check("fl_c4_if_done",  {31'd0, if_done}, 0);
    check("fl_c4_if_rdata", if_rdata, 32'hA5A5_0080);
    next_cycle(); #1;
    check("fl_c5_ext_req",  {31'd0, ext_req}, 0);

    // Reset in the middle of a data access
    next_cycle();
    wait_states = 5;
    mem_r_en = 1'b1;
    mem_addr = 32'h400;
    next_cycle(); #1;
    check("rm_c1_ext_req", {31'd0, ext_req}, 1);
    next_cycle();
    rst      = 1'b1;
    mem_r_en = 1'b0;
    #1;
    check("rm_ext_req",    {31'd0, ext_req}, 0);
    check("rm_ext_addr",   ext_addr,  0);
    check("rm_mem_rdata",  mem_rdata, 0);
    check("rm_if_rdata",   if_rdata,  0);
    check("rm_freeze_all", {31'd0, freeze_all}, 0);
    next_cycle();
    rst = 1'b0;
    repeat (6) next_cycle();
    #1;
    check("rm_after_ext_req", {31'd0, ext_req}, 0);

`ifdef ARB_STARVE_GUARD_EN
    // Starvation guard: four data grants, the waiting fetch, then data #5
    begin
      int n_data = 0;
      bit fetch_done = 1'b0;
      int cyc = 0;
      next_cycle();
      wait_states = 0;
      if_req   = 1'b1;
      if_addr  = 32'h500;
      mem_r_en = 1'b1;
      mem_addr = 32'h600;
      push(1'b1, 32'hA5A5_0600);
      push(1'b1, 32'hA5A5_0610);
      push(1'b1, 32'hA5A5_0620);
      push(1'b1, 32'hA5A5_0630);
      push(1'b0, 32'hA5A5_0500);
      push(1'b1, 32'hA5A5_0640);
      while ((n_data < 5 || !fetch_done) && cyc < 200) begin
        next_cycle();
        cyc++;
        if (mem_done) begin
          n_data++;
          if (n_data == 5) mem_r_en = 1'b0;
          else mem_addr = 32'h600 + 32'(n_data) * 32'h10;
        end
        if (if_done) begin
          fetch_done = 1'b1;
          if_req     = 1'b0;
        end
      end
      check("starve_in_time", {31'd0, cyc < 200}, 1);
    end
`endif

    repeat (3) next_cycle();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
